// File: rtl/uart_recv_block_if.sv
// Block output handshake between the UART block receiver and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_recv_block_if;
  logic [63:0] data_out;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output data_out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  data_out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_recv_block.sv
// 8N1 UART receiver assembling eight bytes, big-endian, into a 64-bit block
// presented on a valid/ready handshake.
module uart_recv_block #(
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_SPEED_MHZ = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  uart_recv_block_if.master   m_out,
  output logic [3:0]          byte_count,
  output logic                frame_err,
  output logic                overrun
);

  localparam int CYCLES_WAIT = CLOCK_SPEED_MHZ * 1000000 / BAUD_RATE;
  localparam int HALF_WAIT   = CYCLES_WAIT / 2;
  localparam int CW          = $clog2(CYCLES_WAIT + 2);
  localparam logic [CW-1:0] C_FULL = CW'(CYCLES_WAIT);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_byte;
  logic [55:0]   r_shift;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_sync1         <= 1'b1;
      r_rx_s          <= 1'b1;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_byte          <= '0;
      r_shift         <= '0;
      byte_count      <= '0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
      m_out.data_out  <= '0;
      m_out.out_valid <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (m_out.out_valid && m_out.out_ready)
        m_out.out_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt         <= '0;
            r_byte[r_idx] <= r_rx_s;
            if (r_idx == 3'd7)
              r_state <= S_STOP;
            else
              r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_shift <= {r_shift[47:0], r_byte};
              if (byte_count == 4'd7) begin
                byte_count      <= '0;
                m_out.data_out  <= {r_shift, r_byte};
                m_out.out_valid <= 1'b1;
                // an accept on this same edge frees the slot: no overrun
                overrun <= m_out.out_valid && !m_out.out_ready;
              end else begin
                byte_count <= byte_count + 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_s)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv_block.sv
// Directed + randomized bench for uart_recv_block at 11 clk per bit,
// checked against a byte-queue block model.
module tb_uart_recv_block;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] byte_count;
  logic       frame_err;
  logic       overrun;

  uart_recv_block_if bus();

  uart_recv_block #(
    .BAUD_RATE      (100000),
    .CLOCK_SPEED_MHZ(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .m_out     (bus),
    .byte_count(byte_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_vcyc = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic        prev_v = 1'b0;
  logic [63:0] prev_d = '0;

  // record every newly presented block and count output pulses
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    if (bus.out_valid === 1'b1) begin
      n_vcyc++;
      if (!prev_v || bus.data_out !== prev_d)
        got_q.push_back(bus.data_out);
    end
    prev_v = (bus.out_valid === 1'b1);
    prev_d = bus.data_out;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [63:0] blk;
    part_q.push_back(b);
    if (part_q.size() == 8) begin
      blk = '0;
      foreach (part_q[i]) blk = {blk[55:0], part_q[i]};
      exp_q.push_back(blk);
      part_q.delete();
    end
  endtask

  // even-indexed frame bits last p0 clk, odd-indexed bits p1 clk
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int p0, input int p1);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      cyc((k % 2 == 0) ? p0 : p1);
    end
    if (stop) model_byte(b);
  endtask

  task automatic send_block(input logic [63:0] blk,
                            input int p0, input int p1);
    for (int i = 0; i < 8; i++)
      send_frame(blk[63-8*i -: 8], 1'b1, p0, p1);
  endtask

  task automatic cmp_blocks(input string tag);
    chk({tag, "_nblk"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_blk"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] fixed;
    int          f0;
    int          o0;

    bus.out_ready = 1'b1;
    reset = 1'b0;
    cyc(3);
    chk("rst_data", bus.data_out, 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_bcnt", 64'(byte_count), 64'h0);
    chk("rst_ferr", 64'(frame_err), 64'h0);
    chk("rst_ovr", 64'(overrun), 64'h0);
    reset = 1'b1;
    cyc(5);

    // assembly order, back-to-back bytes
    fixed = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) begin
      send_frame(fixed[63-8*i -: 8], 1'b1, 11, 11);
      chk("t1_bcnt", 64'(byte_count), 64'((i + 1) % 8));
    end
    cyc(5);
    chk("t1_vcyc", 64'(n_vcyc), 64'd1);
    chk("t1_ferr", 64'(n_ferr), 64'd0);
    chk("t1_ovr", 64'(n_ovr), 64'd0);
    cmp_blocks("t1");

    // random bytes with random idle gaps
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) begin
        send_frame(8'($urandom), 1'b1, 11, 11);
        cyc($urandom_range(0, 15));
      end
    cyc(5);
    chk("t1r_vcyc", 64'(n_vcyc), 64'd3);
    cmp_blocks("t1r");

    // held block
    bus.out_ready = 1'b0;
    send_block(64'h85E813540F0AB405, 11, 11);
    cyc(1);
    for (int i = 0; i < 50; i++) begin
      chk("t2_hold_v", 64'(bus.out_valid), 64'h1);
      chk("t2_hold_d", bus.data_out, 64'h85E813540F0AB405);
      cyc(1);
    end
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    chk("t2_drop", 64'(bus.out_valid), 64'h0);
    cmp_blocks("t2");

    // glitch, then framing error with a held break
    bus.out_ready = 1'b1;
    f0 = n_ferr;
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(30);
    chk("t3_glitch_bcnt", 64'(byte_count), 64'h0);
    chk("t3_glitch_ferr", 64'(n_ferr - f0), 64'h0);
    send_frame(8'h5A, 1'b0, 11, 11);
    cyc(30);
    rx = 1'b1;
    cyc(5);
    chk("t3_ferr", 64'(n_ferr - f0), 64'h1);
    chk("t3_bcnt0", 64'(byte_count), 64'h0);
    send_frame(8'h3C, 1'b1, 11, 11);
    chk("t3_bcnt1", 64'(byte_count), 64'h1);
    for (int i = 0; i < 7; i++)
      send_frame(8'($urandom), 1'b1, 11, 11);
    cyc(5);
    cmp_blocks("t3");

    // overrun
    bus.out_ready = 1'b0;
    o0 = n_ovr;
    send_block(64'h1111111111111111, 11, 11);
    chk("t4_no_ovr", 64'(n_ovr - o0), 64'h0);
    send_block(64'h2222222222222222, 11, 11);
    cyc(2);
    chk("t4_ovr", 64'(n_ovr - o0), 64'h1);
    chk("t4_valid", 64'(bus.out_valid), 64'h1);
    chk("t4_data", bus.data_out, 64'h2222222222222222);
    cmp_blocks("t4");
    bus.out_ready = 1'b1;
    cyc(1);
    bus.out_ready = 1'b0;
    chk("t4_drop", 64'(bus.out_valid), 64'h0);

    // reset in the middle of the 4th byte
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send_frame(8'($urandom), 1'b1, 11, 11);
    rx = 1'b0;
    cyc(11);
    for (int i = 0; i < 4; i++) begin
      rx = 1'($urandom);
      cyc(11);
    end
    reset = 1'b0;
    rx = 1'b1;
    cyc(1);
    chk("t5_data", bus.data_out, 64'h0);
    chk("t5_valid", 64'(bus.out_valid), 64'h0);
    chk("t5_bcnt", 64'(byte_count), 64'h0);
    chk("t5_ferr", 64'(frame_err), 64'h0);
    chk("t5_ovr", 64'(overrun), 64'h0);
    reset = 1'b1;
    part_q.delete();
    cyc(20);
    send_block(64'hFEDCBA9876543210, 11, 11);
    cyc(5);
    cmp_blocks("t5");

    // bit-period jitter between 10 and 12 clk
    f0 = n_ferr;
    send_block(64'h0123456789ABCDEF, 10, 12);
    cyc(20);
    send_block(64'h0123456789ABCDEF, 12, 10);
    cyc(5);
    chk("t6_ferr", 64'(n_ferr - f0), 64'h0);
    cmp_blocks("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv_block.md
Name: uart_recv_block

Overview:
- UART receiver that collects 8 serial bytes into one 64-bit block for the DES datapath.
- It is the receive side of the board serial link and the counterpart of the 64-bit block transmitter.
- Byte order is big-endian: the first byte received becomes data_out[63:56] and the eighth becomes data_out[7:0].
- Each byte is 8N1 and arrives LSB first. A completed block is held on a valid/ready handshake until the consumer takes it.

Parameters:
- BAUD_RATE, 115200, serial bit rate.
- CLOCK_SPEED_MHZ, 50, clk frequency in MHz.
- CYCLES_WAIT (derived, integer), CLOCK_SPEED_MHZ*1e6/BAUD_RATE, truncated. Bit period is CYCLES_WAIT+1 clk cycles (434 → 435 at defaults).
- HALF_WAIT (derived), CYCLES_WAIT/2, truncated.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- data_out  out  64  last completed block; first byte received in [63:56].
- out_valid  out  1  high while data_out holds a block not yet accepted.
- out_ready  in  1  consumer accept; the block transfers on a cycle with out_valid && out_ready.
- byte_count  out  4  bytes of the current block received so far (0..7).
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new block completed while out_valid was still high.

Behaviour:
- Reset (reset==0 at posedge) applies regardless of state:
  - data_out=0, out_valid=0, byte_count=0, frame_err=0, overrun=0.
  - FSM goes to IDLE; cycle counter and bit index are 0.
  - Synchronizer flops are set to 1.
  - A byte or block in flight is discarded.
- rx passes through a 2-flop synchronizer; rx_s denotes the second flop. All decisions use rx_s.
- FSM states and transitions:
  - IDLE: when rx_s==0, clear the counter and go to START.
  - START: count to HALF_WAIT.
    - If rx_s==0 then, go to DATA with bit index 0 and counter 0.
    - Else it was a glitch: go to IDLE.
  - DATA: count 0..CYCLES_WAIT. At CYCLES_WAIT, sample rx_s into bit[index] (LSB first) and clear the counter.
    - After index 7, go to STOP.
  - STOP: at CYCLES_WAIT, sample rx_s.
    - If 1: the byte is accepted; go to IDLE.
    - If 0: pulse frame_err, discard the byte, leave byte_count unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as repeated starts.
- Sampling falls at mid-bit, so IDLE is re-entered mid stop bit and a back-to-back next start edge is caught.
- Byte accept:
  - shift_reg[55:0] <= {shift_reg[47:0], byte}.
  - byte_count increments.
  - On the 8th byte (byte_count==7):
    - data_out <= {shift_reg[55:0], byte} on the same edge.
    - out_valid <= 1 from the next cycle.
    - byte_count wraps to 0.
- Latency: out_valid rises one clk after the 8th stop-bit sample edge, i.e. about 3 clk after the mid stop bit on the pin, counting synchronizer delay.
- Handshake:
  - out_valid drops on the cycle after out_valid && out_ready.
  - data_out is stable while out_valid is high, except on overrun.
  - out_ready while out_valid==0 is ignored.
- Simultaneous events:
  - If accept of the held block coincides with completion of a new block: out_valid stays 1, data_out takes the new block, no overrun.
  - If a new block completes while out_valid==1 and out_ready==0: data_out is overwritten with the new block, out_valid stays 1, overrun pulses one cycle.
- Reception never stalls; the receiver has no flow control back to the sender.
- byte_count is not cleared by frame_err; only reset re-aligns block boundaries.

Test Plan:
- Use CLOCK_SPEED_MHZ=1, BAUD_RATE=100000 in every scenario, giving CYCLES_WAIT=10 and a bit period of 11 clk.
1. Assembly and order:
   - Stimulus: reset low 3 cycles, out_ready=1. Send bytes 01,23,45,67,89,AB,CD,EF back-to-back, 8N1 at 11 clk/bit.
   - Required: byte_count steps 1..7 then 0; a single out_valid pulse with data_out=64'h0123456789ABCDEF; frame_err=0, overrun=0.
2. Held block:
   - Stimulus: out_ready=0; send block 85E813540F0AB405; hold out_ready low 50 cycles, then raise it for 1 cycle.
   - Required: out_valid high the whole interval with data_out constant at 85E813540F0AB405; out_valid low the following cycle.
3. Glitch and frame error:
   - Stimulus: 3-clk low pulse on rx.
   - Required: no state change; byte_count stays 0.
   - Stimulus: byte 0x5A with stop bit low, rx low 30 more clk, then a valid byte 0x3C.
   - Required: frame_err pulses once; byte_count 0→0→1; shift_reg[7:0]=3C.
4. Overrun:
   - Stimulus: out_ready=0; send blocks 1111111111111111 then 2222222222222222.
   - Required: overrun pulses once at the second completion; data_out=2222222222222222; out_valid stays high.
5. Reset mid-byte:
   - Stimulus: after 3 bytes, assert reset in the middle of the 4th byte's data bits.
   - Required: all outputs are at reset values the next cycle. A fresh 8-byte block FEDCBA9876543210 is then received exactly, with no stale bytes.
6. Timing margin:
   - Stimulus: sender bit period 10 and 12 clk (±9%).
   - Required: block 0123456789ABCDEF is still received correctly with no frame_err.
